// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory wait, illegal-op detection and PC enable
module mips_multicycle_ctrl #(
    parameter int ALUCTRL_W = 3,
    parameter bit EN_BNE    = 1'b1,
    parameter bit EN_JAL    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 iord,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 imm_zext,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           pc_src,
    output logic                 illegal_op,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_JUMP    = 4'd10,
        S_JAL     = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        CL_RTYPE = 3'd0,
        CL_LW    = 3'd1,
        CL_SW    = 3'd2,
        CL_BEQ   = 3'd3,
        CL_BNE   = 3'd4,
        CL_ADDI  = 3'd5,
        CL_ANDI  = 3'd6,
        CL_ORI   = 3'd7
    } class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic [ALUCTRL_W-1:0] alu_code(input logic [2:0] c);
        return ALUCTRL_W'(c);
    endfunction

    state_e state_q, state_d, cur_state;
    class_e class_q, class_d;

    state_e     dec_state;
    class_e     dec_class;
    logic       dec_illegal;
    logic       funct_legal;
    logic [2:0] rtype_alu;
    logic       imm_class;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            class_q <= CL_RTYPE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    always_comb begin
        funct_legal = 1'b1;
        rtype_alu   = ALU_ADD;
        case (funct)
            F_ADD:   rtype_alu = ALU_ADD;
            F_SUB:   rtype_alu = ALU_SUB;
            F_AND:   rtype_alu = ALU_AND;
            F_OR:    rtype_alu = ALU_OR;
            F_SLT:   rtype_alu = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    // Instruction decode; the class is latched in DECODE so later states do not depend on the IR opcode.
    always_comb begin
        dec_state   = S_FETCH;
        dec_class   = CL_RTYPE;
        dec_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct_legal) dec_state = S_RTEXEC;
                else             dec_illegal = 1'b1;
            end
            OP_LW:   begin dec_state = S_MEMADR;  dec_class = CL_LW;   end
            OP_SW:   begin dec_state = S_MEMADR;  dec_class = CL_SW;   end
            OP_BEQ:  begin dec_state = S_BRANCH;  dec_class = CL_BEQ;  end
            OP_BNE: begin
                if (EN_BNE) begin
                    dec_state = S_BRANCH;
                    dec_class = CL_BNE;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_ADDI: begin dec_state = S_IMMEXEC; dec_class = CL_ADDI; end
            OP_ANDI: begin dec_state = S_IMMEXEC; dec_class = CL_ANDI; end
            OP_ORI:  begin dec_state = S_IMMEXEC; dec_class = CL_ORI;  end
            OP_J:    dec_state = S_JUMP;
            OP_JAL: begin
                if (EN_JAL) dec_state = S_JAL;
                else        dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign imm_class = (class_q == CL_ADDI) || (class_q == CL_ANDI) || (class_q == CL_ORI);

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b01;
        imm_zext    = 1'b0;
        alu_control = alu_code(ALU_ADD);
        pc_src      = 2'b00;
        illegal_op  = 1'b0;

        // Selects show FETCH values while reset is held.
        cur_state = rst ? state_q : S_FETCH;

        case (cur_state)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                state_d    = dec_state;
                class_d    = dec_class;
                illegal_op = dec_illegal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (class_q == CL_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_MEMWB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_RTEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b00;
                alu_control = alu_code(rtype_alu);
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = imm_class ? 2'b00 : 2'b01;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b00;
                alu_control = alu_code(ALU_SUB);
                pc_src      = 2'b01;
                pc_en       = zero ^ (class_q == CL_BNE);
                state_d     = S_FETCH;
            end
            S_IMMEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (class_q)
                    CL_ANDI: begin alu_control = alu_code(ALU_AND); imm_zext = 1'b1; end
                    CL_ORI:  begin alu_control = alu_code(ALU_OR);  imm_zext = 1'b1; end
                    default: alu_control = alu_code(ALU_ADD);
                endcase
                state_d = S_ALUWB;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (!rst) begin
            pc_en      = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule
